// File: rtl/pc_restore_unit.sv
// pc_restore_unit
//   Memory-stage sequencer for RET/RTI. Pops the return context off the data
//   stack in reverse push order (flags, PC low, PC high), captures each 16-bit
//   word, then presents the restored 32-bit PC and 3-bit flags with one-cycle
//   load strobes. Holds busy (pipeline stall) for the whole sequence.
//
//   Build option: define PC_RESTORE_FLAGS_EN to enable the flags pop for RTI.
//   Without it, RTI is sequenced exactly like RET, flags_out is 0 and
//   flags_load never fires.
//
// Ports
//   clk          in   pipeline clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start        in   pop request, sampled only in IDLE
//   is_rti       in   1 = RTI (also pop flags), 0 = RET; latched at start
//   flush        in   synchronous abort back to IDLE, suppresses strobes
//   mem_data_in  in   [15:0] read word, valid the cycle after mem_rd_en
//   mem_rd_en    out  data-memory read strobe at current SP
//   pc_segment   out  [1:0] 00 = PC high, 01 = PC low, 10 = flags
//   sp_inc       out  one pulse per popped word
//   busy         out  high in every non-IDLE state
//   pc_out       out  [31:0] restored PC {pc_h, pc_l}
//   flags_out    out  [2:0] restored flags
//   pc_load      out  one-cycle strobe, fetch loads pc_out
//   flags_load   out  one-cycle strobe, flag register loads flags_out
//
// state    | meaning
// IDLE     | waiting for start
// RD_FLAGS | reading flags word (RTI only)
// RD_PCL   | reading PC low; flags word arrives this cycle
// RD_PCH   | reading PC high; PC low word arrives this cycle
// CAP_PCH  | no read; PC high word arrives this cycle
// LOAD     | pc_load / flags_load strobe

module pc_restore_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_rti,
  input  logic        flush,
  input  logic [15:0] mem_data_in,
  output logic        mem_rd_en,
  output logic [1:0]  pc_segment,
  output logic        sp_inc,
  output logic        busy,
  output logic [31:0] pc_out,
  output logic [2:0]  flags_out,
  output logic        pc_load,
  output logic        flags_load
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_FLAGS = 3'd1,
    RD_PCL   = 3'd2,
    RD_PCH   = 3'd3,
    CAP_PCH  = 3'd4,
    LOAD     = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic        rd_q;
  logic [1:0]  seg_q;
  logic        busy_q;
  logic        pc_load_q;
  logic [31:0] pc_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
`ifdef PC_RESTORE_FLAGS_EN
          state_d = is_rti ? RD_FLAGS : RD_PCL;
`else
          state_d = RD_PCL;
`endif
        end
      end
      RD_FLAGS: state_d = RD_PCL;
      RD_PCL:   state_d = RD_PCH;
      RD_PCH:   state_d = CAP_PCH;
      CAP_PCH:  state_d = LOAD;
      LOAD:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // Outputs are registered from the next state so they line up with the
  // state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rd_q      <= 1'b0;
      seg_q     <= 2'b00;
      busy_q    <= 1'b0;
      pc_load_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_q      <= (state_d == RD_FLAGS) || (state_d == RD_PCL) || (state_d == RD_PCH);
      seg_q     <= (state_d == RD_FLAGS) ? 2'b10 :
                   (state_d == RD_PCL)   ? 2'b01 : 2'b00;
      busy_q    <= (state_d != IDLE);
      pc_load_q <= (state_d == LOAD);
    end
  end

  // Each word arrives one cycle after its read, i.e. in the following state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= 32'h0;
    end else if (!flush) begin
      if (state_q == RD_PCH)  pc_q[15:0]  <= mem_data_in;
      if (state_q == CAP_PCH) pc_q[31:16] <= mem_data_in;
    end
  end

`ifdef PC_RESTORE_FLAGS_EN
  logic       rti_q;
  logic [2:0] flags_q;
  logic       flags_load_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rti_q        <= 1'b0;
      flags_q      <= 3'b000;
      flags_load_q <= 1'b0;
    end else begin
      if (state_q == IDLE && start && !flush) rti_q <= is_rti;
      // RD_PCL follows RD_FLAGS exactly when the latched op is RTI.
      if (state_q == RD_PCL && rti_q && !flush) flags_q <= mem_data_in[2:0];
      flags_load_q <= (state_d == LOAD) && rti_q;
    end
  end

  assign flags_out  = flags_q;
  assign flags_load = flags_load_q & ~flush;
`else
  logic unused_is_rti;
  assign unused_is_rti = is_rti;
  assign flags_out     = 3'b000;
  assign flags_load    = 1'b0;
`endif

  // Flush kills strobes in the cycle it is asserted as well as afterwards.
  assign mem_rd_en  = rd_q & ~flush;
  assign sp_inc     = rd_q & ~flush;
  assign pc_segment = seg_q;
  assign busy       = busy_q;
  assign pc_load    = pc_load_q & ~flush;
  assign pc_out     = pc_q;

endmodule

// File: tb/tb_pc_restore_unit.sv
module tb_pc_restore_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_rti;
  logic        flush;
  logic [15:0] mem_data_in;
  logic        mem_rd_en;
  logic [1:0]  pc_segment;
  logic        sp_inc;
  logic        busy;
  logic [31:0] pc_out;
  logic [2:0]  flags_out;
  logic        pc_load;
  logic        flags_load;

  int vecs;
  int errs;
  int sp_cnt;
  logic [15:0] words [4];

  pc_restore_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .is_rti      (is_rti),
    .flush       (flush),
    .mem_data_in (mem_data_in),
    .mem_rd_en   (mem_rd_en),
    .pc_segment  (pc_segment),
    .sp_inc      (sp_inc),
    .busy        (busy),
    .pc_out      (pc_out),
    .flags_out   (flags_out),
    .pc_load     (pc_load),
    .flags_load  (flags_load)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stack memory model: one-cycle read latency, word selected by segment.
  always @(posedge clk) begin
    if (mem_rd_en) mem_data_in <= words[pc_segment];
  end

  initial sp_cnt = 0;
  always @(posedge clk) begin
    if (sp_inc) sp_cnt <= sp_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) step();
    vecs++; if (busy !== 1'b0)       begin errs++; $display("FAIL reset_busy got %b want 0", busy); end
    vecs++; if (mem_rd_en !== 1'b0)  begin errs++; $display("FAIL reset_rd got %b want 0", mem_rd_en); end
    vecs++; if (sp_inc !== 1'b0)     begin errs++; $display("FAIL reset_sp got %b want 0", sp_inc); end
    vecs++; if (pc_segment !== 2'b00) begin errs++; $display("FAIL reset_seg got %b want 00", pc_segment); end
    vecs++; if (pc_out !== 32'h0)    begin errs++; $display("FAIL reset_pc got %h want 0", pc_out); end
    vecs++; if (flags_out !== 3'b0)  begin errs++; $display("FAIL reset_flags got %b want 0", flags_out); end
    vecs++; if (pc_load !== 1'b0)    begin errs++; $display("FAIL reset_pcl got %b want 0", pc_load); end
    vecs++; if (flags_load !== 1'b0) begin errs++; $display("FAIL reset_fl got %b want 0", flags_load); end
    rst_n = 1'b1;
    step();
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_ret();
    logic [6:1] e_rd, e_busy, e_pcl;
    logic [1:0] e_seg [1:6];
    int base;
    e_rd   = 6'b000011;
    e_busy = 6'b001111;
    e_pcl  = 6'b001000;
    e_seg  = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    words[0] = 16'h1234; words[1] = 16'h5678; words[2] = 16'hFFF5;
    base = sp_cnt;
    is_rti = 1'b0;
    start  = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      start = 1'b0;
      vecs++; if (mem_rd_en !== e_rd[c])   begin errs++; $display("FAIL ret_rd c%0d got %b want %b", c, mem_rd_en, e_rd[c]); end
      vecs++; if (busy !== e_busy[c])      begin errs++; $display("FAIL ret_busy c%0d got %b want %b", c, busy, e_busy[c]); end
      vecs++; if (pc_load !== e_pcl[c])    begin errs++; $display("FAIL ret_pcl c%0d got %b want %b", c, pc_load, e_pcl[c]); end
      vecs++; if (flags_load !== 1'b0)     begin errs++; $display("FAIL ret_fl c%0d got %b want 0", c, flags_load); end
      if (e_rd[c]) begin
        vecs++; if (pc_segment !== e_seg[c]) begin errs++; $display("FAIL ret_seg c%0d got %b want %b", c, pc_segment, e_seg[c]); end
      end
      if (c == 4) begin
        vecs++; if (pc_out !== 32'h12345678) begin errs++; $display("FAIL ret_pc got %h want 12345678", pc_out); end
        vecs++; if (flags_out !== 3'b000)    begin errs++; $display("FAIL ret_flags got %b want 000", flags_out); end
      end
    end
    vecs++; if (sp_cnt - base != 2) begin errs++; $display("FAIL ret_spcnt got %0d want 2", sp_cnt - base); end
  endtask

  task automatic test_rti();
    logic [6:1] e_rd, e_busy, e_pcl, e_fl;
    logic [1:0] e_seg [1:6];
    logic [2:0] e_flags;
    int e_sp, pc_c, base;
`ifdef PC_RESTORE_FLAGS_EN
    e_rd    = 6'b000111;
    e_busy  = 6'b011111;
    e_pcl   = 6'b010000;
    e_fl    = 6'b010000;
    e_seg   = '{2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
    e_flags = 3'b101;
    e_sp    = 3;
    pc_c    = 5;
`else
    e_rd    = 6'b000011;
    e_busy  = 6'b001111;
    e_pcl   = 6'b001000;
    e_fl    = 6'b000000;
    e_seg   = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    e_flags = 3'b000;
    e_sp    = 2;
    pc_c    = 4;
`endif
    words[0] = 16'h0002; words[1] = 16'h0010; words[2] = 16'hFFF5;
    base = sp_cnt;
    is_rti = 1'b1;
    start  = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      start = 1'b0;
      vecs++; if (mem_rd_en !== e_rd[c])  begin errs++; $display("FAIL rti_rd c%0d got %b want %b", c, mem_rd_en, e_rd[c]); end
      vecs++; if (busy !== e_busy[c])     begin errs++; $display("FAIL rti_busy c%0d got %b want %b", c, busy, e_busy[c]); end
      vecs++; if (pc_load !== e_pcl[c])   begin errs++; $display("FAIL rti_pcl c%0d got %b want %b", c, pc_load, e_pcl[c]); end
      vecs++; if (flags_load !== e_fl[c]) begin errs++; $display("FAIL rti_fl c%0d got %b want %b", c, flags_load, e_fl[c]); end
      if (e_rd[c]) begin
        vecs++; if (pc_segment !== e_seg[c]) begin errs++; $display("FAIL rti_seg c%0d got %b want %b", c, pc_segment, e_seg[c]); end
      end
      if (c == pc_c) begin
        vecs++; if (pc_out !== 32'h00020010) begin errs++; $display("FAIL rti_pc got %h want 00020010", pc_out); end
        vecs++; if (flags_out !== e_flags)   begin errs++; $display("FAIL rti_flags got %b want %b", flags_out, e_flags); end
      end
    end
    is_rti = 1'b0;
    vecs++; if (sp_cnt - base != e_sp) begin errs++; $display("FAIL rti_spcnt got %0d want %0d", sp_cnt - base, e_sp); end
  endtask

  task automatic test_flush();
    int base;
    words[0] = 16'hAAAA; words[1] = 16'hBBBB;
    base = sp_cnt;
    is_rti = 1'b0;
    start  = 1'b1;
    step();
    start = 1'b0;
    step();
    flush = 1'b1;
    #1;
    vecs++; if (sp_inc !== 1'b0)    begin errs++; $display("FAIL flush_sp got %b want 0", sp_inc); end
    vecs++; if (mem_rd_en !== 1'b0) begin errs++; $display("FAIL flush_rd got %b want 0", mem_rd_en); end
    step();
    flush = 1'b0;
    for (int c = 3; c <= 6; c++) begin
      vecs++; if (busy !== 1'b0)    begin errs++; $display("FAIL flush_busy c%0d got %b want 0", c, busy); end
      vecs++; if (pc_load !== 1'b0) begin errs++; $display("FAIL flush_pcl c%0d got %b want 0", c, pc_load); end
      step();
    end
    vecs++; if (sp_cnt - base != 1) begin errs++; $display("FAIL flush_spcnt got %0d want 1", sp_cnt - base); end
    // flush and start together in IDLE: flush wins
    start = 1'b1;
    flush = 1'b1;
    step();
    start = 1'b0;
    flush = 1'b0;
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL flush_start_busy got %b want 0", busy); end
    step();
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL flush_start_busy2 got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int base;
    words[0] = 16'hCAFE; words[1] = 16'hBEEF;
    base = sp_cnt;
    is_rti = 1'b0;
    start  = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
      start = (c == 2 || c == 5) ? 1'b1 : 1'b0;
      if (c == 4) begin
        vecs++; if (pc_load !== 1'b1)        begin errs++; $display("FAIL b2b_pcl1 got %b want 1", pc_load); end
        vecs++; if (pc_out !== 32'hCAFEBEEF) begin errs++; $display("FAIL b2b_pc1 got %h want cafebeef", pc_out); end
      end
      if (c == 5) begin
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL b2b_idle got %b want 0", busy); end
      end
      if (c == 6) begin
        vecs++; if (busy !== 1'b1)         begin errs++; $display("FAIL b2b_busy2 got %b want 1", busy); end
        vecs++; if (mem_rd_en !== 1'b1)    begin errs++; $display("FAIL b2b_rd2 got %b want 1", mem_rd_en); end
        vecs++; if (pc_segment !== 2'b01)  begin errs++; $display("FAIL b2b_seg2 got %b want 01", pc_segment); end
        words[0] = 16'h0BAD; words[1] = 16'hF00D;
      end
      if (c == 9) begin
        vecs++; if (pc_load !== 1'b1)        begin errs++; $display("FAIL b2b_pcl2 got %b want 1", pc_load); end
        vecs++; if (pc_out !== 32'h0BADF00D) begin errs++; $display("FAIL b2b_pc2 got %h want 0badf00d", pc_out); end
      end
      if (c == 10) begin
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL b2b_end got %b want 0", busy); end
      end
    end
    vecs++; if (sp_cnt - base != 4) begin errs++; $display("FAIL b2b_spcnt got %0d want 4", sp_cnt - base); end
  endtask

  task automatic test_reset_mid();
    words[0] = 16'h1111; words[1] = 16'h2222;
    is_rti = 1'b0;
    start  = 1'b1;
    step();
    start = 1'b0;
    step();
    vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL rmid_pre_busy got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    vecs++; if (busy !== 1'b0)        begin errs++; $display("FAIL rmid_busy got %b want 0", busy); end
    vecs++; if (mem_rd_en !== 1'b0)   begin errs++; $display("FAIL rmid_rd got %b want 0", mem_rd_en); end
    vecs++; if (sp_inc !== 1'b0)      begin errs++; $display("FAIL rmid_sp got %b want 0", sp_inc); end
    vecs++; if (pc_out !== 32'h0)     begin errs++; $display("FAIL rmid_pc got %h want 0", pc_out); end
    vecs++; if (flags_out !== 3'b000) begin errs++; $display("FAIL rmid_flags got %b want 0", flags_out); end
    step();
    rst_n = 1'b1;
    step();
    vecs++; if (busy !== 1'b0)    begin errs++; $display("FAIL rmid_idle got %b want 0", busy); end
    vecs++; if (pc_load !== 1'b0) begin errs++; $display("FAIL rmid_pcl got %b want 0", pc_load); end
  endtask

  initial begin
    vecs   = 0;
    errs   = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    is_rti = 1'b0;
    flush  = 1'b0;
    words[0] = 16'h0; words[1] = 16'h0; words[2] = 16'h0; words[3] = 16'h0;
    test_reset();
    test_ret();
    test_rti();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
